// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage MIPS pipeline: it detects RAW hazards
// that forwarding cannot cover, owns the mult/div busy countdown, and counts stalled cycles.
module hazard_ctrl (
  input  logic        hazard_clk_i,
  input  logic        hazard_rst_n_i,
  input  logic [31:0] hazard_str_D_i,
  input  logic [31:0] hazard_str_E_i,
  input  logic [31:0] hazard_str_M_i,
  output logic        hazard_stall_F_o,
  output logic        hazard_stall_D_o,
  output logic        hazard_clr_E_o,
  output logic        hazard_busy_o,
  output logic [31:0] hazard_stallcnt_o
);
  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  typedef struct packed {
    logic cal_r, cal_i, load, store, br, jr, jal, md, mf, mt;
  } cls_t;

  // Operand demand of the D-stage instruction.
  typedef struct packed {
    logic       use_rs, use_rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic       hilo;
  } src_t;

  function automatic cls_t classify(input logic [31:0] ins);
    cls_t c;
    c = '0;
    if (ins[31:26] == 6'b000000) begin
      case (ins[5:0])
        6'b100001, 6'b100011, 6'b100100,
        6'b100101, 6'b101010, 6'b000000: c.cal_r = 1'b1;
        6'b001000:                       c.jr    = 1'b1;
        6'b011000, 6'b011001,
        6'b011010, 6'b011011:            c.md    = 1'b1;
        6'b010000, 6'b010010:            c.mf    = 1'b1;
        6'b010001, 6'b010011:            c.mt    = 1'b1;
        default: ;
      endcase
    end else begin
      case (ins[31:26])
        6'b001101, 6'b001111, 6'b001001: c.cal_i = 1'b1;
        6'b100011:                       c.load  = 1'b1;
        6'b101011:                       c.store = 1'b1;
        6'b000100:                       c.br    = 1'b1;
        6'b000011:                       c.jal   = 1'b1;
        default: ;
      endcase
    end
    return c;
  endfunction

  // A destination of $0 reads as "none", so it never matches a nonzero source.
  function automatic logic [4:0] dst_of(input logic [31:0] ins);
    cls_t c;
    c = classify(ins);
    if (c.cal_r || c.mf)        return ins[15:11];
    else if (c.cal_i || c.load) return ins[20:16];
    else if (c.jal)             return 5'd31;
    else                        return 5'd0;
  endfunction

  function automatic logic [1:0] tnew_e_of(input logic [31:0] ins);
    cls_t c;
    c = classify(ins);
    if (c.load)                        return 2'd2;
    else if (c.cal_r || c.cal_i || c.mf) return 2'd1;
    else                               return 2'd0;
  endfunction

  function automatic logic [1:0] tnew_m_of(input logic [31:0] ins);
    cls_t c;
    c = classify(ins);
    return c.load ? 2'd1 : 2'd0;
  endfunction

  function automatic logic is_md(input logic [31:0] ins);
    cls_t c;
    c = classify(ins);
    return c.md;
  endfunction

  function automatic src_t src_of(input logic [31:0] ins);
    cls_t c;
    src_t s;
    c = classify(ins);
    s.use_rs  = c.br | c.jr | c.cal_r | c.cal_i | c.load | c.store | c.md | c.mt;
    s.tuse_rs = (c.br || c.jr) ? 2'd0 : 2'd1;
    s.use_rt  = c.br | c.cal_r | c.md | c.store;
    s.tuse_rt = c.br ? 2'd0 : (c.store ? 2'd2 : 2'd1);
    s.hilo    = c.md | c.mf | c.mt;
    return s;
  endfunction

  src_t       src_d;
  logic [4:0] rs_d, rt_d, dst_e, dst_m;
  logic [1:0] tnew_e, tnew_m;
  logic       md_e, div_e;
  logic       data_stall, md_stall, stall;
  logic [3:0] busy_cnt;
  logic [31:0] stall_cnt;

  always_comb begin
    src_d  = src_of(hazard_str_D_i);
    rs_d   = hazard_str_D_i[25:21];
    rt_d   = hazard_str_D_i[20:16];
    dst_e  = dst_of(hazard_str_E_i);
    dst_m  = dst_of(hazard_str_M_i);
    tnew_e = tnew_e_of(hazard_str_E_i);
    tnew_m = tnew_m_of(hazard_str_M_i);
    md_e   = is_md(hazard_str_E_i);
    div_e  = hazard_str_E_i[1];
  end

  always_comb begin
    data_stall = 1'b0;
    if (src_d.use_rs && rs_d != 5'd0) begin
      if (rs_d == dst_e && src_d.tuse_rs < tnew_e) data_stall = 1'b1;
      if (rs_d == dst_m && src_d.tuse_rs < tnew_m) data_stall = 1'b1;
    end
    if (src_d.use_rt && rt_d != 5'd0) begin
      if (rt_d == dst_e && src_d.tuse_rt < tnew_e) data_stall = 1'b1;
      if (rt_d == dst_m && src_d.tuse_rt < tnew_m) data_stall = 1'b1;
    end
    md_stall = src_d.hilo && (hazard_busy_o || md_e);
    stall    = data_stall | md_stall;
  end

  // A start arriving while the unit is already counting is ignored.
  always_ff @(posedge hazard_clk_i or negedge hazard_rst_n_i) begin
    if (!hazard_rst_n_i)               busy_cnt <= 4'd0;
    else if (busy_cnt == 4'd0 && md_e) busy_cnt <= div_e ? DIV_LAT : MULT_LAT;
    else if (busy_cnt != 4'd0)         busy_cnt <= busy_cnt - 4'd1;
  end

  always_ff @(posedge hazard_clk_i or negedge hazard_rst_n_i) begin
    if (!hazard_rst_n_i) stall_cnt <= 32'd0;
    else if (stall)      stall_cnt <= stall_cnt + 32'd1;
  end

  assign hazard_busy_o     = (busy_cnt != 4'd0);
  assign hazard_stall_F_o  = stall;
  assign hazard_stall_D_o  = stall;
  assign hazard_clr_E_o    = stall;
  assign hazard_stallcnt_o = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random instruction mixes,
// all compared against a table-driven reference model of the hazard rules.
module tb_hazard_ctrl;
  logic        clk, rst_n;
  logic [31:0] d, e, m;
  logic        stall_f, stall_d, clr_e, busy;
  logic [31:0] scnt;

  int          n_cmp, n_bad;
  int          m_busy;
  logic [31:0] m_scnt;

  hazard_ctrl dut (
    .hazard_clk_i      (clk),
    .hazard_rst_n_i    (rst_n),
    .hazard_str_D_i    (d),
    .hazard_str_E_i    (e),
    .hazard_str_M_i    (m),
    .hazard_stall_F_o  (stall_f),
    .hazard_stall_D_o  (stall_d),
    .hazard_clr_E_o    (clr_e),
    .hazard_busy_o     (busy),
    .hazard_stallcnt_o (scnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] rty(input logic [5:0] fn, input int rs, input int rt, input int rd);
    logic [4:0] a, b, c;
    a = rs[4:0]; b = rt[4:0]; c = rd[4:0];
    return {6'b000000, a, b, c, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] ity(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    logic [4:0] a, b;
    a = rs[4:0]; b = rt[4:0];
    return {op, a, b, imm};
  endfunction

  // ---------------- reference model ----------------
  function automatic string kind(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26]; fn = ins[5:0];
    if (op == 6'b000000) begin
      if (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b100100 || fn == 6'b100101 ||
          fn == 6'b101010 || fn == 6'b000000) return "cal_r";
      if (fn == 6'b001000) return "jr";
      if (fn >= 6'b011000 && fn <= 6'b011011) return "md";
      if (fn == 6'b010000 || fn == 6'b010010) return "mf";
      if (fn == 6'b010001 || fn == 6'b010011) return "mt";
      return "nop";
    end
    if (op == 6'b001101 || op == 6'b001111 || op == 6'b001001) return "cal_i";
    if (op == 6'b100011) return "load";
    if (op == 6'b101011) return "store";
    if (op == 6'b000100) return "br";
    if (op == 6'b000011) return "jal";
    return "nop";
  endfunction

  function automatic int dst(input logic [31:0] ins);
    string k;
    k = kind(ins);
    if (k == "cal_r" || k == "mf") return int'(ins[15:11]);
    if (k == "cal_i" || k == "load") return int'(ins[20:16]);
    if (k == "jal") return 31;
    return 0;
  endfunction

  // 99 marks an operand that is never read.
  function automatic int tuse(input string k, input int which);
    if (which == 0) begin
      if (k == "br" || k == "jr") return 0;
      if (k == "cal_r" || k == "cal_i" || k == "load" || k == "store" || k == "md" || k == "mt") return 1;
    end else begin
      if (k == "br") return 0;
      if (k == "cal_r" || k == "md") return 1;
      if (k == "store") return 2;
    end
    return 99;
  endfunction

  function automatic int tnew(input string k, input int stage);
    if (stage == 0) begin
      if (k == "load") return 2;
      if (k == "cal_r" || k == "cal_i" || k == "mf") return 1;
    end else if (k == "load") return 1;
    return 0;
  endfunction

  function automatic bit ref_stall();
    string kd;
    int src[2], tu[2], dx[2], tn[2];
    bit s;
    kd = kind(d);
    src[0] = int'(d[25:21]); src[1] = int'(d[20:16]);
    tu[0] = tuse(kd, 0);     tu[1] = tuse(kd, 1);
    dx[0] = dst(e);          dx[1] = dst(m);
    tn[0] = tnew(kind(e), 0); tn[1] = tnew(kind(m), 1);
    s = 0;
    for (int i = 0; i < 2; i++)
      for (int x = 0; x < 2; x++)
        if (src[i] != 0 && src[i] == dx[x] && tu[i] < tn[x]) s = 1;
    if ((kd == "md" || kd == "mf" || kd == "mt") && (m_busy > 0 || kind(e) == "md")) s = 1;
    return s;
  endfunction

  task automatic drive(input logic [31:0] dd, input logic [31:0] ee, input logic [31:0] mm);
    d = dd; e = ee; m = mm;
    #2;
  endtask

  task automatic tick();
    bit s;
    s = ref_stall();
    @(posedge clk);
    if (rst_n) begin
      if (s) m_scnt = m_scnt + 32'd1;
      if (m_busy == 0 && kind(e) == "md")
        m_busy = (e[5:0] == 6'b011010 || e[5:0] == 6'b011011) ? 10 : 5;
      else if (m_busy > 0) m_busy--;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_ins();
    int a, b, c;
    a = $urandom_range(0, 3); b = $urandom_range(0, 3); c = $urandom_range(0, 3);
    case ($urandom_range(0, 11))
      0:  return rty(6'b100001, a, b, c);
      1:  return rty(6'b101010, a, b, c);
      2:  return rty(6'b000000, 0, b, c) | 32'h40;
      3:  return ity(6'b001101, a, b, 16'h1234);
      4:  return ity(6'b100011, a, b, 16'h0004);
      5:  return ity(6'b101011, a, b, 16'h0008);
      6:  return ity(6'b000100, a, b, 16'hfffe);
      7:  return rty(6'b001000, a, 0, 0);
      8:  return {6'b000011, 26'h0000100};
      9:  return rty(6'b011000 + 6'($urandom_range(0, 3)), a, b, 0);
      10: return ($urandom_range(0, 1) != 0) ? rty(6'b010010, 0, 0, c) : rty(6'b010011, a, 0, 0);
      default: return NOP;
    endcase
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(NOP, NOP, NOP);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({stall_f, stall_d, clr_e, busy} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 0000", {stall_f, stall_d, clr_e, busy});
    end
    n_cmp++;
    if (scnt !== 32'd0) begin n_bad++; $display("FAIL reset_stallcnt: got %0d want 0", scnt); end
    m_busy = 0; m_scnt = 32'd0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(NOP, NOP, NOP);
      tick();
    end
    n_cmp++;
    if (scnt !== 32'd0) begin n_bad++; $display("FAIL reset_after_release: got %0d want 0", scnt); end
  endtask

  task automatic test_load_use();
    logic [31:0] c0, addu, lw;
    c0 = m_scnt;
    addu = rty(6'b100001, 1, 4, 3);
    lw   = ity(6'b100011, 2, 1, 16'h0000);
    drive(addu, lw, NOP);
    n_cmp++;
    if ({stall_f, stall_d, clr_e} !== 3'b111) begin
      n_bad++; $display("FAIL load_use_stall: got %b want 111", {stall_f, stall_d, clr_e});
    end
    tick();
    drive(addu, NOP, lw);
    n_cmp++;
    if ({stall_f, stall_d, clr_e} !== 3'b000) begin
      n_bad++; $display("FAIL load_use_release: got %b want 000", {stall_f, stall_d, clr_e});
    end
    tick();
    n_cmp++;
    if (scnt !== c0 + 32'd1) begin n_bad++; $display("FAIL load_use_count: got %0d want %0d", scnt, c0 + 1); end
  endtask

  task automatic test_branch();
    logic [31:0] c0, beq, lw, ori;
    int got;
    beq = ity(6'b000100, 5, 0, 16'h0010);
    lw  = ity(6'b100011, 2, 5, 16'h0000);
    ori = ity(6'b001101, 0, 5, 16'h00ff);
    c0 = m_scnt; got = 0;
    drive(beq, lw, NOP);  got += int'(stall_d); tick();
    drive(beq, NOP, lw);  got += int'(stall_d); tick();
    drive(beq, NOP, NOP); got += int'(stall_d); tick();
    n_cmp++;
    if (got != 2) begin n_bad++; $display("FAIL branch_after_load: got %0d stalls want 2", got); end
    n_cmp++;
    if (scnt !== c0 + 32'd2) begin n_bad++; $display("FAIL branch_load_count: got %0d want %0d", scnt, c0 + 2); end
    got = 0;
    drive(beq, ori, NOP); got += int'(clr_e); tick();
    drive(beq, NOP, ori); got += int'(clr_e); tick();
    n_cmp++;
    if (got != 1) begin n_bad++; $display("FAIL branch_after_ori: got %0d stalls want 1", got); end
  endtask

  task automatic test_reg_zero();
    logic [31:0] c0;
    c0 = m_scnt;
    drive(rty(6'b100001, 0, 0, 3), ity(6'b100011, 2, 0, 16'h0), NOP);
    n_cmp++;
    if (stall_f !== 1'b0) begin n_bad++; $display("FAIL reg_zero_stall: got %b want 0", stall_f); end
    tick();
    n_cmp++;
    if (scnt !== c0) begin n_bad++; $display("FAIL reg_zero_count: got %0d want %0d", scnt, c0); end
  endtask

  task automatic run_md(input string name, input logic [31:0] op, input int want_stall, input int want_busy);
    int ns, nb, cyc;
    logic [31:0] c0, mflo;
    mflo = rty(6'b010010, 0, 0, 3);
    c0 = m_scnt; ns = 0; nb = 0; cyc = 0;
    drive(mflo, op, NOP);
    while (stall_d === 1'b1 && cyc < 30) begin
      ns++; nb += int'(busy);
      tick(); cyc++;
      drive(mflo, NOP, (cyc == 1) ? op : NOP);
    end
    n_cmp++;
    if (cyc >= 30) begin n_bad++; $display("FAIL %s_timeout: stall never released", name); end
    n_cmp++;
    if (ns != want_stall) begin n_bad++; $display("FAIL %s_stalls: got %0d want %0d", name, ns, want_stall); end
    n_cmp++;
    if (nb != want_busy) begin n_bad++; $display("FAIL %s_busy: got %0d want %0d", name, nb, want_busy); end
    tick();
    n_cmp++;
    if (scnt !== c0 + 32'(want_stall)) begin
      n_bad++; $display("FAIL %s_count: got %0d want %0d", name, scnt, c0 + 32'(want_stall));
    end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] dv;
    dv = rty(6'b011010, 1, 2, 0);
    drive(NOP, dv, NOP); tick();
    drive(NOP, NOP, dv); tick();
    drive(NOP, NOP, NOP); tick();
    drive(NOP, NOP, NOP);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_div_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || scnt !== 32'd0) begin
      n_bad++; $display("FAIL mid_div_reset: busy %b cnt %0d want 0 0", busy, scnt);
    end
    m_busy = 0; m_scnt = 32'd0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(rty(6'b010010, 0, 0, 3), NOP, NOP);
    n_cmp++;
    if (stall_d !== 1'b0) begin n_bad++; $display("FAIL mid_div_mflo: got %b want 0", stall_d); end
    tick();
  endtask

  task automatic test_random();
    bit s;
    for (int i = 0; i < 400; i++) begin
      drive(rand_ins(), rand_ins(), rand_ins());
      s = ref_stall();
      n_cmp++;
      if ({stall_f, stall_d, clr_e} !== {3{s}} || busy !== (m_busy > 0) || scnt !== m_scnt) begin
        n_bad++;
        $display("FAIL random_%0d: d=%h e=%h m=%h got stall=%b%b%b busy=%b cnt=%0d want stall=%b busy=%b cnt=%0d",
                 i, d, e, m, stall_f, stall_d, clr_e, busy, scnt, s, m_busy > 0, m_scnt);
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; m_busy = 0; m_scnt = 32'd0;
    rst_n = 1'b0; d = NOP; e = NOP; m = NOP;
    test_reset();
    test_load_use();
    test_reset();
    test_branch();
    test_reg_zero();
    run_md("mult", rty(6'b011000, 1, 2, 0), 6, 5);
    run_md("divu", rty(6'b011011, 1, 2, 0), 11, 10);
    test_reset_mid_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
